// File: rtl/snake_pixel_renderer.sv
// Snake game pixel renderer: double-buffered segment set, frame-synchronous commit, 2-stage colour pipeline.
// Optional background grid lines are enabled by defining SNAKE_GRID_LINES_EN.
module snake_pixel_renderer #(
  parameter int MAX_SEG  = 16,
  parameter int H_OFFSET = 144,
  parameter int V_OFFSET = 35
) (
  input  logic       clk100Mhz,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       bright,
  input  logic       seg_wr_en,
  input  logic [3:0] seg_wr_idx,
  input  logic [5:0] seg_wr_x,
  input  logic [4:0] seg_wr_y,
  input  logic [4:0] shadow_len,
  input  logic [5:0] food_x,
  input  logic [4:0] food_y,
  input  logic       commit_req,
  output logic       commit_ack,
  output logic       frame_start,
  output logic [7:0] rgb
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t       state_q;
  logic         prev_nz_q;
  logic         commit_ack_q;
  logic         frame_start_q;
  logic [4:0]   act_len_q;
  logic [5:0]   act_food_x_q;
  logic [4:0]   act_food_y_q;
  logic [5:0]   sh_x_q  [MAX_SEG];
  logic [4:0]   sh_y_q  [MAX_SEG];
  logic [5:0]   act_x_q [MAX_SEG];
  logic [4:0]   act_y_q [MAX_SEG];

  logic         frame_edge;
  logic         do_copy;
  logic [4:0]   len_clamped;

  assign frame_edge = (hCount == 10'd0) && (vCount == 10'd0) && prev_nz_q;
  assign do_copy    = (state_q == PENDING) && frame_edge;

  always_comb begin
    len_clamped = shadow_len;
    if (shadow_len == 5'd0)
      len_clamped = 5'd1;
    else if (shadow_len > 5'(MAX_SEG))
      len_clamped = 5'(MAX_SEG);
  end

  // Commit FSM; frame_start and commit_ack go high together with the active-set update.
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      state_q       <= IDLE;
      prev_nz_q     <= 1'b0;
      commit_ack_q  <= 1'b0;
      frame_start_q <= 1'b0;
      act_len_q     <= 5'd1;
      act_food_x_q  <= 6'd10;
      act_food_y_q  <= 5'd10;
    end else begin
      prev_nz_q     <= (hCount != 10'd0) || (vCount != 10'd0);
      frame_start_q <= frame_edge;
      commit_ack_q  <= do_copy;
      case (state_q)
        IDLE: begin
          if (commit_req)
            state_q <= PENDING;
        end
        PENDING: begin
          if (frame_edge) begin
            state_q      <= IDLE;
            act_len_q    <= len_clamped;
            act_food_x_q <= food_x;
            act_food_y_q <= food_y;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The copy reads pre-edge shadow contents, so a same-cycle write is left out of it.
  always_ff @(posedge clk100Mhz) begin
    for (int i = 0; i < MAX_SEG; i++) begin
      if (rst) begin
        sh_x_q[i]  <= (i == 0) ? 6'd20 : 6'd0;
        sh_y_q[i]  <= (i == 0) ? 5'd15 : 5'd0;
        act_x_q[i] <= (i == 0) ? 6'd20 : 6'd0;
        act_y_q[i] <= (i == 0) ? 5'd15 : 5'd0;
      end else begin
        if (do_copy) begin
          act_x_q[i] <= sh_x_q[i];
          act_y_q[i] <= sh_y_q[i];
        end
        if (seg_wr_en && (int'(seg_wr_idx) == i)) begin
          sh_x_q[i] <= seg_wr_x;
          sh_y_q[i] <= seg_wr_y;
        end
      end
    end
  end

  logic [5:0]         col_c;
  logic [4:0]         row_c;
  logic [MAX_SEG-1:0] hit_c;
  logic               food_c;

  assign col_c  = 6'((hCount - 10'(H_OFFSET)) >> 4);
  assign row_c  = 5'((vCount - 10'(V_OFFSET)) >> 4);
  assign food_c = (act_food_x_q == col_c) && (act_food_y_q == row_c);

  for (genvar gi = 0; gi < MAX_SEG; gi++) begin : g_hit
    assign hit_c[gi] = (5'(gi) < act_len_q) && (act_x_q[gi] == col_c) && (act_y_q[gi] == row_c);
  end

  logic [5:0]         col_q;
  logic [4:0]         row_q;
  logic               bright_q;
  logic               food_q;
  logic [MAX_SEG-1:0] hit_q;
  logic [7:0]         rgb_q;
  logic [7:0]         rgb_d;
  logic               wall_d;
`ifdef SNAKE_GRID_LINES_EN
  logic               grid_q;
`endif

  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      col_q    <= 6'd0;
      row_q    <= 5'd0;
      bright_q <= 1'b0;
      food_q   <= 1'b0;
      hit_q    <= '0;
      rgb_q    <= 8'h00;
`ifdef SNAKE_GRID_LINES_EN
      grid_q   <= 1'b0;
`endif
    end else begin
      col_q    <= col_c;
      row_q    <= row_c;
      bright_q <= bright;
      food_q   <= food_c;
      hit_q    <= hit_c;
      rgb_q    <= rgb_d;
`ifdef SNAKE_GRID_LINES_EN
      grid_q   <= (4'(hCount - 10'(H_OFFSET)) == 4'd0) || (4'(vCount - 10'(V_OFFSET)) == 4'd0);
`endif
    end
  end

  assign wall_d = (col_q == 6'd0) || (col_q == 6'd39) || (row_q == 5'd0) || (row_q == 5'd29);

  always_comb begin
    rgb_d = 8'h00;
    if (!bright_q)
      rgb_d = 8'h00;
    else if (hit_q[0])
      rgb_d = 8'hFC;
    else if (|(hit_q >> 1))
      rgb_d = 8'h1C;
    else if (food_q)
      rgb_d = 8'hE0;
    else if (wall_d)
      rgb_d = 8'h92;
`ifdef SNAKE_GRID_LINES_EN
    else if (grid_q)
      rgb_d = 8'h49;
`endif
  end

  assign rgb         = rgb_q;
  assign commit_ack  = commit_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Bench for snake_pixel_renderer: directed scenarios then randomized snakes, checked every cycle
// against a cell-level reference model of the snake, food and commit rules.
module tb_snake_pixel_renderer;

  logic       clk100Mhz = 1'b0;
  logic       rst;
  logic [9:0] hCount, vCount;
  logic       bright;
  logic       seg_wr_en;
  logic [3:0] seg_wr_idx;
  logic [5:0] seg_wr_x;
  logic [4:0] seg_wr_y;
  logic [4:0] shadow_len;
  logic [5:0] food_x;
  logic [4:0] food_y;
  logic       commit_req;
  logic       commit_ack;
  logic       frame_start;
  logic [7:0] rgb;

  always #5 clk100Mhz = ~clk100Mhz;

  snake_pixel_renderer dut (
    .clk100Mhz  (clk100Mhz),
    .rst        (rst),
    .hCount     (hCount),
    .vCount     (vCount),
    .bright     (bright),
    .seg_wr_en  (seg_wr_en),
    .seg_wr_idx (seg_wr_idx),
    .seg_wr_x   (seg_wr_x),
    .seg_wr_y   (seg_wr_y),
    .shadow_len (shadow_len),
    .food_x     (food_x),
    .food_y     (food_y),
    .commit_req (commit_req),
    .commit_ack (commit_ack),
    .frame_start(frame_start),
    .rgb        (rgb)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: shadow/active snake as plain cell coordinates.
  int         sh_x[16], sh_y[16], ac_x[16], ac_y[16];
  int         ac_len, ac_fx, ac_fy;
  bit         pending, prev_nz;
  logic [7:0] prev_exp;
  int         fs_cnt, ack_cnt;

  function automatic int clamp_len(int l);
    if (l == 0) return 1;
    if (l > 16) return 16;
    return l;
  endfunction

  function automatic logic [7:0] model_rgb(int h, int v, logic b);
    int x, y, col, row;
    bit body;
    if (!b) return 8'h00;
    x   = (h - 144) & 1023;
    y   = (v - 35) & 1023;
    col = x / 16;
    row = (y / 16) % 32;
    if (ac_x[0] == col && ac_y[0] == row) return 8'hFC;
    body = 0;
    for (int i = 1; i < ac_len; i++)
      if (ac_x[i] == col && ac_y[i] == row) body = 1;
    if (body) return 8'h1C;
    if (ac_fx == col && ac_fy == row) return 8'hE0;
    if (col == 0 || col == 39 || row == 0 || row == 29) return 8'h92;
`ifdef SNAKE_GRID_LINES_EN
    if ((x % 16) == 0 || (y % 16) == 0) return 8'h49;
`endif
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      sh_x[i] = (i == 0) ? 20 : 0;
      sh_y[i] = (i == 0) ? 15 : 0;
      ac_x[i] = sh_x[i];
      ac_y[i] = sh_y[i];
    end
    ac_len   = 1;
    ac_fx    = 10;
    ac_fy    = 10;
    pending  = 0;
    prev_nz  = 0;
    prev_exp = 8'h00;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the currently driven inputs; predicts and checks all outputs.
  task automatic step();
    logic [7:0] e_rgb, e_now;
    bit e_fs, e_ack;
    if (rst) begin
      model_reset();
      e_rgb = 8'h00;
      e_fs  = 0;
      e_ack = 0;
    end else begin
      e_now = model_rgb(int'(hCount), int'(vCount), bright);
      e_fs  = (hCount == 0) && (vCount == 0) && prev_nz;
      e_ack = pending && e_fs;
      if (e_ack) begin
        for (int i = 0; i < 16; i++) begin
          ac_x[i] = sh_x[i];
          ac_y[i] = sh_y[i];
        end
        ac_len = clamp_len(int'(shadow_len));
        ac_fx  = int'(food_x);
        ac_fy  = int'(food_y);
      end
      if (seg_wr_en) begin
        sh_x[seg_wr_idx] = int'(seg_wr_x);
        sh_y[seg_wr_idx] = int'(seg_wr_y);
      end
      if (e_ack) pending = 0;
      else if (!pending && commit_req) pending = 1;
      prev_nz  = (hCount != 0) || (vCount != 0);
      e_rgb    = prev_exp;
      prev_exp = e_now;
    end
    @(posedge clk100Mhz);
    #1;
    chk("rgb", rgb, e_rgb);
    chk("frame_start", 8'(frame_start), 8'(e_fs));
    chk("commit_ack", 8'(commit_ack), 8'(e_ack));
    fs_cnt  += int'(frame_start);
    ack_cnt += int'(commit_ack);
  endtask

  task automatic pix(int h, int v, logic b);
    hCount = 10'(h);
    vCount = 10'(v);
    bright = b;
    step();
  endtask

  task automatic wr_seg(int idx, int x, int y);
    seg_wr_en  = 1'b1;
    seg_wr_idx = 4'(idx);
    seg_wr_x   = 6'(x);
    seg_wr_y   = 5'(y);
    pix(300, 300, 1'b1);
    seg_wr_en  = 1'b0;
  endtask

  task automatic frame_sweep();
    pix(799, 524, 1'b0);
    pix(0, 0, 1'b0);
    $display("frame: frame_start=%0d commit_ack=%0d active_len=%0d", frame_start, commit_ack, ac_len);
  endtask

  task automatic request_commit(int len);
    shadow_len = 5'(len);
    commit_req = 1'b1;
    pix(300, 300, 1'b1);
    commit_req = 1'b0;
  endtask

  initial begin
    int a0, f0, n, idx, h, v;
    rst = 1'b1; hCount = '0; vCount = '0; bright = 1'b0;
    seg_wr_en = 1'b0; seg_wr_idx = '0; seg_wr_x = '0; seg_wr_y = '0;
    shadow_len = 5'd1; food_x = 6'd10; food_y = 5'd10; commit_req = 1'b0;
    fs_cnt = 0; ack_cnt = 0;
    model_reset();

    // reset state
    repeat (3) step();
    chk("reset_rgb", rgb, 8'h00);
    rst = 1'b0;

    // head at reset position, two-cycle latency
    pix(464, 275, 1'b1);
    pix(464, 275, 1'b1);
    chk("head_after_reset", rgb, 8'hFC);

    // body segment via commit
    wr_seg(1, 21, 15);
    request_commit(2);
    a0 = ack_cnt;
    frame_sweep();
    chk("ack_with_frame_start", {6'd0, commit_ack, frame_start}, 8'h03);
    pix(480, 275, 1'b1);
    pix(480, 275, 1'b1);
    chk("body_after_commit", rgb, 8'h1C);
    chk_int("single_ack", ack_cnt - a0, 1);

    // held zero counts give one pulse
    pix(5, 5, 1'b0);
    f0 = fs_cnt;
    repeat (4) pix(0, 0, 1'b0);
    chk_int("held_zero_pulses", fs_cnt - f0, 1);

    // bright gating and wall colour
    pix(144, 35, 1'b0);
    pix(144, 35, 1'b1);
    chk("dark_cell00", rgb, 8'h00);
    pix(144, 35, 1'b1);
    chk("wall_cell00", rgb, 8'h92);

    // repeated requests then reset: pending commit discarded
    wr_seg(2, 22, 15);
    request_commit(5);
    request_commit(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    a0 = ack_cnt;
    frame_sweep();
    frame_sweep();
    chk_int("no_ack_after_reset", ack_cnt - a0, 0);
    pix(480, 275, 1'b1);
    pix(480, 275, 1'b1);
    chk("seg1_gone_after_reset", rgb, 8'h00);

    // length clamping
    for (int i = 0; i < 16; i++) wr_seg(i, 5 + i, 5);
    request_commit(0);
    frame_sweep();
    pix(144 + 6 * 16, 35 + 5 * 16, 1'b1);
    pix(144 + 5 * 16, 35 + 5 * 16, 1'b1);
    chk("len0_no_body", rgb, 8'h00);
    pix(300, 300, 1'b1);
    chk("len0_head", rgb, 8'hFC);
    request_commit(20);
    frame_sweep();
    pix(144 + 20 * 16, 35 + 5 * 16, 1'b1);
    pix(300, 300, 1'b1);
    chk("len20_last_seg", rgb, 8'h1C);

    // request coincident with frame start in IDLE
    shadow_len = 5'd3;
    pix(700, 400, 1'b0);
    commit_req = 1'b1;
    hCount = '0; vCount = '0;
    step();
    commit_req = 1'b0;
    chk("coincident_no_ack", 8'(commit_ack), 8'h00);
    frame_sweep();
    chk("coincident_next_ack", 8'(commit_ack), 8'h01);

    // randomized snakes
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++)
        wr_seg($urandom_range(0, 15), $urandom_range(0, 39), $urandom_range(0, 29));
      food_x = 6'($urandom_range(0, 39));
      food_y = 5'($urandom_range(0, 29));
      if ($urandom_range(0, 3) != 0) request_commit($urandom_range(0, 31));
      pix(799, 524, 1'b0);
      seg_wr_en  = 1'($urandom_range(0, 1));
      seg_wr_idx = 4'($urandom_range(0, 15));
      seg_wr_x   = 6'($urandom_range(0, 39));
      seg_wr_y   = 5'($urandom_range(0, 29));
      commit_req = 1'($urandom_range(0, 1));
      pix(0, 0, 1'b0);
      seg_wr_en  = 1'b0;
      commit_req = 1'b0;
      $display("random %0d: frame_start=%0d commit_ack=%0d active_len=%0d", it, frame_start, commit_ack, ac_len);
      for (int k = 0; k < 12; k++) begin
        if (k % 2 == 0) begin
          idx = $urandom_range(0, 15);
          h = 144 + ac_x[idx] * 16 + $urandom_range(0, 15);
          v = 35 + ac_y[idx] * 16 + $urandom_range(0, 15);
          pix(h, v, 1'($urandom_range(0, 7) != 0));
        end else begin
          pix($urandom_range(144, 783), $urandom_range(35, 514), 1'($urandom_range(0, 3) != 0));
        end
      end
    end
    pix(300, 300, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
